// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: redirect in, ROM address/data, and decoder dequeue side.
// The master modport is the fetch_queue view; slave is the surrounding core/testbench.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            redirect;
  logic [XLEN-1:0] redirectAddr;
  logic [XLEN-1:0] imemAddr;
  logic            imemReq;
  logic [XLEN-1:0] imemData;
  logic            deqReady;
  logic            deqValid;
  logic [XLEN-1:0] deqInst;
  logic [XLEN-1:0] deqPc;
  logic [CW-1:0]   count;

  modport master (
    input  redirect, redirectAddr, imemData, deqReady,
    output imemAddr, imemReq, deqValid, deqInst, deqPc, count
  );

  modport slave (
    output redirect, redirectAddr, imemData, deqReady,
    input  imemAddr, imemReq, deqValid, deqInst, deqPc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC and buffers up to DEPTH {pc, inst} pairs; 1-cycle fetch-to-head.
// Decode stalls via deqReady=0; fetch continues until full, then PC holds; redirect flushes everything.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] ent_pc_q   [DEPTH];
  logic [XLEN-1:0] ent_inst_q [DEPTH];

  logic deq_vld;
  logic pop;
  logic push;
  logic unused_addr_bits;

  // Reset gating keeps the head invisible during the reset cycle even if the queue held entries.
  assign deq_vld = !reset && (count_q != '0);
  assign pop     = deq_vld && bus.deqReady;
  assign push    = !bus.redirect && !reset && ((count_q < DEPTH_C) || pop);

  assign bus.imemAddr = pc_q;
  assign bus.imemReq  = push;
  assign bus.deqValid = deq_vld;
  assign bus.deqInst  = deq_vld ? ent_inst_q[rd_ptr_q] : NOP_INST;
  assign bus.deqPc    = deq_vld ? ent_pc_q[rd_ptr_q]   : '0;
  assign bus.count    = count_q;

  assign unused_addr_bits = ^bus.redirectAddr[1:0];

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (reset) begin
      pc_d     = RESET_PC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (bus.redirect) begin
      pc_d     = {bus.redirectAddr[XLEN-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]   <= pc_q;
      ent_inst_q[wr_ptr_q] <= bus.imemData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= DEPTH_C);
      assert (bus.deqValid == (count_q != '0));
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue: a behavioural queue model predicts every output each cycle.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] m_pc;
  ent_t        sb[$];

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  assign bus.imemData = rom(bus.imemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model across the rising edge.
  task automatic cycle(input logic rst, input logic redir, input logic [31:0] addr, input logic rdy);
    logic        m_vld;
    logic        m_pop;
    logic        m_push;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    ent_t        e;
    reset            = rst;
    bus.redirect     = redir;
    bus.redirectAddr = addr;
    bus.deqReady     = rdy;
    @(negedge clk);
    m_vld  = !rst && (sb.size() != 0);
    m_pop  = m_vld && rdy;
    m_push = !redir && !rst && ((sb.size() < DEPTH) || m_pop);
    exp_inst = NOP;
    exp_pc   = 32'h0;
    if (m_vld) begin
      exp_inst = sb[0].inst;
      exp_pc   = sb[0].pc;
    end
    chk("imemAddr", bus.imemAddr, m_pc);
    chk("imemReq", 32'(bus.imemReq), 32'(m_push));
    chk("deqValid", 32'(bus.deqValid), 32'(m_vld));
    chk("deqInst", bus.deqInst, exp_inst);
    chk("deqPc", bus.deqPc, exp_pc);
    chk("count", 32'(bus.count), 32'(sb.size()));
    if (rst) begin
      m_pc = RESET_PC;
      sb.delete();
    end else if (redir) begin
      m_pc = addr & 32'hFFFF_FFFC;
      sb.delete();
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        e.pc   = m_pc;
        e.inst = rom(m_pc);
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirectAddr = 32'h0;
    bus.deqReady     = 1'b0;
    m_pc             = RESET_PC;
    @(posedge clk);
    #1;
    sb.delete();

    // Second reset cycle is fully checked; then streaming with decode always ready.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream_head_pc", bus.deqPc, 32'd28);
    chk("stream_head_inst", bus.deqInst, 32'd107);

    // Flush to 0, then stall until full and hold.
    cycle(1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_full_count", 32'(bus.count), 32'd4);
    chk("stall_pc_hold", bus.imemAddr, 32'd16);
    chk("stall_head_pc", bus.deqPc, 32'd0);
    // Release: full with simultaneous pop keeps count at DEPTH across the pointer wrap.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_pop_count", 32'(bus.count), 32'd4);
    chk("full_pop_head_pc", bus.deqPc, 32'd24);

    // Three entries queued, then redirect to 0x42 with deqReady high.
    cycle(1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h42, 1'b1);
    chk("redir_addr", bus.imemAddr, 32'h40);
    chk("redir_count", 32'(bus.count), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_head_pc", bus.deqPc, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset beats redirect.
    cycle(1'b1, 1'b1, 32'h80, 1'b1);
    chk("rst_redir_pc", bus.imemAddr, RESET_PC);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // PC wraps past the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", bus.imemAddr, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Random mix of stalls and occasional redirects.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, ($urandom_range(0, 11) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
